// File: rtl/pow_calc_if.sv
// Start/busy/done handshake bundle for the iterative power unit.
interface pow_calc_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (output start, base, exp, input result, busy, done, ovf);
    modport slave  (input start, base, exp, output result, busy, done, ovf);
endinterface

// File: rtl/pow_calc.sv
// Iterative unsigned base^exp, one saturating multiply per clock.
// Optional macro POW_EARLY_EXIT_EN finishes early on overflow or base<=1.
module pow_calc #(
    parameter int WIDTH = 7
) (
    input  logic      clk,
    input  logic      rst,
    pow_calc_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   b_r, b_n;
    logic [WIDTH-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [WIDTH-1:0]   result, res_n;
    logic               busy, busy_n;
    logic               done, done_n;
    logic               ovf, ovf_n;
    logic [2*WIDTH-1:0] prod;
    logic               finish;
`ifdef POW_EARLY_EXIT_EN
    logic               stepped, step_n;
`endif

    assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, b_r};

`ifdef POW_EARLY_EXIT_EN
    // Base 0/1 cannot change acc after the first multiply; overflow is sticky.
    assign finish = (cnt == '0) || ovf || ((b_r <= WIDTH'(1)) && stepped);
`else
    assign finish = (cnt == '0);
`endif

    always_comb begin
        state_n = state;
        b_n     = b_r;
        cnt_n   = cnt;
        acc_n   = acc;
        res_n   = result;
        busy_n  = busy;
        done_n  = 1'b0;
        ovf_n   = ovf;
`ifdef POW_EARLY_EXIT_EN
        step_n  = stepped;
`endif
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (bus.start) begin
                    b_n     = bus.base;
                    cnt_n   = bus.exp;
                    acc_n   = WIDTH'(1);
                    ovf_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = CALC;
`ifdef POW_EARLY_EXIT_EN
                    step_n  = 1'b0;
`endif
                end
            end
            CALC: begin
                if (finish) begin
                    res_n   = ovf ? '1 : acc;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    if (|prod[2*WIDTH-1:WIDTH]) begin
                        acc_n = '1;
                        ovf_n = 1'b1;
                    end else begin
                        acc_n = prod[WIDTH-1:0];
                    end
                    cnt_n = cnt - WIDTH'(1);
`ifdef POW_EARLY_EXIT_EN
                    step_n = 1'b1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            b_r     <= '0;
            cnt     <= '0;
            acc     <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
`ifdef POW_EARLY_EXIT_EN
            stepped <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            b_r     <= b_n;
            cnt     <= cnt_n;
            acc     <= acc_n;
            result  <= res_n;
            busy    <= busy_n;
            done    <= done_n;
            ovf     <= ovf_n;
`ifdef POW_EARLY_EXIT_EN
            stepped <= step_n;
`endif
        end
    end

    assign bus.result = result;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.ovf    = ovf;
endmodule

// File: tb/tb_pow_calc.sv
// Self-checking bench for pow_calc against an arithmetic power/latency model.
module tb_pow_calc;
    localparam int W    = 7;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pow_calc_if #(.WIDTH(W)) bus ();
    pow_calc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: saturating power and number of cycles from accept to done.
    function automatic void model(input int b, input int e, output int r,
                                  output bit o, output int lat);
        int acc;
        int mults;
        acc = 1; o = 1'b0; mults = e;
        for (int i = 1; i <= e; i++) begin
            acc = acc * b;
            if (acc > MAXV) begin
                acc = MAXV;
                if (!o) begin
                    o = 1'b1;
`ifdef POW_EARLY_EXIT_EN
                    mults = i;
`endif
                end
            end
        end
`ifdef POW_EARLY_EXIT_EN
        if (e > 0 && b <= 1) mults = 1;
`endif
        r = acc;
        lat = mults + 1;
    endfunction

    // Drives one calculation and measures it; returns lat=0 on timeout.
    task automatic do_calc(input int b, input int e, output int lat,
                           output int r, output bit o, output bit busy_ok);
        bus.start = 1'b1;
        bus.base  = W'(b);
        bus.exp   = W'(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.base  = W'($urandom);
        bus.exp   = W'($urandom);
        busy_ok = (bus.busy === 1'b1);
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        r = int'(bus.result);
        o = bus.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.base  = '0;
        bus.exp   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.result, bus.busy, bus.done, bus.ovf} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: result=%0d busy=%b done=%b ovf=%b, required all 0",
                         i, bus.result, bus.busy, bus.done, bus.ovf);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_one(input int b, input int e, input string tag);
        int lat, r, er, el;
        bit o, eo, bok;
        logic [W-1:0] held;
        model(b, e, er, eo, el);
        do_calc(b, e, lat, r, o, bok);
        checks++;
        if (lat != el) begin
            errors++;
            $display("FAIL %s latency %0d^%0d: got %0d required %0d", tag, b, e, lat, el);
        end
        checks++;
        if (r != er || o != eo) begin
            errors++;
            $display("FAIL %s value %0d^%0d: got result=%0d ovf=%b required result=%0d ovf=%b",
                     tag, b, e, r, o, er, eo);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL %s busy %0d^%0d: busy not high throughout or not low at done", tag, b, e);
        end
        held = bus.result;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.result !== held || bus.ovf !== eo) begin
            errors++;
            $display("FAIL %s hold %0d^%0d: done=%b result=%0d ovf=%b required done=0 result=%0d ovf=%b",
                     tag, b, e, bus.done, bus.result, bus.ovf, held, eo);
        end
    endtask

    task automatic test_directed();
        int tb_b[9] = '{2, 3, 5, 2, 3, 0, 0, 1, 2};
        int tb_e[9] = '{6, 4, 3, 7, 5, 0, 5, 100, 10};
        for (int i = 0; i < 9; i++) test_one(tb_b[i], tb_e[i], "directed");
    endtask

    task automatic test_random();
        int b, e;
        for (int i = 0; i < 25; i++) begin
            b = $urandom_range(0, MAXV);
            e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 12);
            test_one(b, e, "random");
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0, at = 0;
        logic [W-1:0] r = '0;
        bus.start = 1'b1; bus.base = 7'd2; bus.exp = 7'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            bus.start = (n == 3);
            if (n == 3) begin bus.base = 7'd3; bus.exp = 7'd1; end
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin ndone++; at = n; r = bus.result; end
        end
        bus.start = 1'b0;
        checks++;
        if (ndone != 1 || at != 7 || r !== 7'd64) begin
            errors++;
            $display("FAIL start_ignored: dones=%0d at E%0d result=%0d required 1 done at E7 result=64",
                     ndone, at, r);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        bus.start = 1'b1; bus.base = 7'd2; bus.exp = 7'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if ({bus.result, bus.busy, bus.done, bus.ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid: result=%0d busy=%b done=%b ovf=%b, required all 0",
                     bus.result, bus.busy, bus.done, bus.ovf);
        end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_mid_abandon: activity cycles=%0d required 0", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int er, el, n1 = 0, n2 = 0;
        bit eo;
        model(3, 2, er, eo, el);
        bus.start = 1'b1; bus.base = 7'd3; bus.exp = 7'd2;
        @(posedge clk); #1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                if (n1 == 0) n1 = n;
                else begin n2 = n; break; end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (n1 != el || n2 != 2 * el + 1 || bus.result !== W'(er)) begin
            errors++;
            $display("FAIL back_to_back: dones at E%0d,E%0d result=%0d required E%0d,E%0d result=%0d",
                     n1, n2, bus.result, el, 2 * el + 1, er);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_stop: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pow_calc.md
# pow_calc

Iterative integer power unit for the calculator datapath. It computes `base^exp` by repeated multiplication, one multiply per clock. It is the inverse companion of the base-2 log unit: it feeds the antilog/power key of the calculator and shares the same 7-bit operand width. It uses a start/busy/done handshake, and results above the representable range saturate and raise an overflow flag.

## Interface
- `WIDTH`, default 7: operand and result width in bits.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-low reset (0 = reset).
- `start`, input, 1: request a calculation; sampled only in IDLE.
- `base`, input, WIDTH: base operand, unsigned; latched on accepted start.
- `exp`, input, WIDTH: exponent, unsigned; latched on accepted start.
- `result`, output, WIDTH: last completed result; held until the next completion.
- `busy`, output, 1: high while a calculation is in progress.
- `done`, output, 1: one-cycle pulse marking the cycle `result` becomes valid.
- `ovf`, output, 1: overflow of the last result; valid with `done`, held with `result`.

## Operation
- **Reset.** On a clock edge with `rst`=0, every register clears:
  - state = IDLE, `result`=0, `busy`=0, `done`=0, `ovf`=0, internal acc/count=0.
  - Reset has priority over everything, including an in-flight calculation, which is abandoned with no `done` pulse.
- **States.**
  - **IDLE.** `busy`=0. If `start`=1 at an edge:
    - b_r←`base`, cnt←`exp`, acc←1, `ovf`←0, state←CALC, `busy`←1.
  - **CALC.** At each edge, if the finish condition holds:
    - `result`←(`ovf` ? 2^WIDTH−1 : acc), `done`←1, `busy`←0, state←IDLE.
  - **CALC, otherwise.**
    - p = acc × b_r, computed at 2·WIDTH bits.
    - If p > 2^WIDTH−1: acc←2^WIDTH−1 and `ovf`←1 (sticky); else acc←p.
    - cnt←cnt−1.
- **Finish condition, base build.** cnt==0.
- **Arithmetic.**
  - Unsigned only.
  - 0^0 = 1; 0^n = 0 for n>0; 1^n = 1.
  - Saturated value is all-ones (127 for WIDTH=7).
- **`done` behaviour.** `done` is 0 in every cycle other than the completion pulse.
- **`start` handling.**
  - `start` while `busy`=1 is ignored; it is not queued.
  - `start` held high re-triggers a new calculation on the first IDLE edge after completion, i.e. the edge following the `done` pulse.
- **Operand stability.** `base`/`exp` changes after acceptance have no effect.

## Timing
- **Latency, base build.** Start accepted at edge E0. Multiplies occur at edges E1..E`exp`. `done`, `result` and `ovf` update at edge E(`exp`+1). Total latency is `exp`+1 cycles.
  - For WIDTH=7: minimum 1 cycle (exp=0), maximum 128 cycles.
- **`busy` span.** `busy` rises at E0+ and falls at the same edge `done` rises.
- **Back-to-back throughput.** One calculation per `exp`+2 cycles, because IDLE consumes one edge.
- **Output hold.** `result`/`ovf` are stable from the `done` edge until the next completion or reset.

## Configuration
- **`POW_EARLY_EXIT_EN` defined.** The finish condition in CALC becomes any of:
  - cnt==0;
  - `ovf`==1;
  - b_r≤1 and at least one multiply performed.
- **Early-exit consequences.**
  - Overflowing calculations complete one cycle after the multiply that overflowed.
  - Base 0/1 with `exp`>0 completes in 2 cycles.
  - Results are identical to the base build; only latency changes.
- **Not defined.** Fixed `exp`+1 latency, as described under Timing.

## Test plan
- **Reset and idle.**
  - Stimulus: hold `rst`=0 for 3 cycles, then release with `start`=0.
  - Required: `result`=0, `busy`=0, `done`=0, `ovf`=0, and they stay so.
- **In-range results, base build.**
  - Stimulus: base=2, exp=6.
    - Required: `done` at E7, `result`=64, `ovf`=0.
  - Stimulus: base=3, exp=4.
    - Required: `result`=81.
  - Stimulus: base=5, exp=3.
    - Required: `result`=125.
- **Overflow.**
  - Stimulus: base=2, exp=7.
    - Required: `result`=127, `ovf`=1, `done` at E8.
  - Stimulus: base=3, exp=5.
    - Required: `result`=127, `ovf`=1.
- **Corner operands.**
  - Stimulus: 0^0.
    - Required: `result`=1 at E1.
  - Stimulus: 0^5.
    - Required: `result`=0.
  - Stimulus: 1^100.
    - Required: `result`=1 at E101 in the base build; at E2 with `POW_EARLY_EXIT_EN`.
- **Handshake and reset mid-operation.**
  - Stimulus: pulse `start` again at E3 during 2^6.
    - Required: ignored; single `done` at E7 with `result`=64.
  - Stimulus: drive `rst`=0 at E4 during 2^6.
    - Required: no `done`, all outputs 0 next cycle.
- **Early-exit latency.**
  - Stimulus: with `POW_EARLY_EXIT_EN`, base=2, exp=10.
    - Required: overflow at E7, `done` at E8 with `result`=127, `ovf`=1.
  - Same stimulus, base build.
    - Required: `done` at E11 with identical outputs.
